rx_cmd_ctrl: RTL and testbench

//   Receive-side command sequencer between the UART receiver and the register file / ALU.

---
 rtl/rx_cmd_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_rx_cmd_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_cmd_ctrl.sv
// Receive-side command sequencer: parses UART byte frames into register-file
// write/read strobes and ALU enables, dropping errored or stalled frames.
//
// Ports:
//   CLK, RST                 clock, asynchronous active-high reset
//   RX_P_DATA / RX_D_VLD     received byte and its one-cycle valid strobe
//   RX_PAR_ERR / RX_STP_ERR  byte error flags, sampled with RX_D_VLD
//   WrEn / RdEn              register-file write / read strobes (1 cycle)
//   Address / WrData         register-file address and write data (held)
//   ALU_EN / ALU_FUN         ALU strobe (1 cycle) and function code (held)
//   CLK_GATE_EN              ALU clock-gate enable
//   busy                     a frame is in progress
//   cmd_err                  one-cycle pulse on bad opcode, errored byte or timeout
module rx_cmd_ctrl #(
    parameter int unsigned             DATA_WIDTH  = 8,
    parameter int unsigned             ADDR_WIDTH  = 4,
    parameter int unsigned             TIMEOUT_CYC = 1024,
    parameter logic [DATA_WIDTH-1:0]   CMD_WR      = 8'hAA,
    parameter logic [DATA_WIDTH-1:0]   CMD_RD      = 8'hBB,
    parameter logic [DATA_WIDTH-1:0]   CMD_ALU_OP  = 8'hCC,
    parameter logic [DATA_WIDTH-1:0]   CMD_ALU_NOP = 8'hDD
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_P_DATA,
    input  logic                  RX_D_VLD,
    input  logic                  RX_PAR_ERR,
    input  logic                  RX_STP_ERR,
    output logic                  WrEn,
    output logic                  RdEn,
    output logic [ADDR_WIDTH-1:0] Address,
    output logic [DATA_WIDTH-1:0] WrData,
    output logic                  ALU_EN,
    output logic [3:0]            ALU_FUN,
    output logic                  CLK_GATE_EN,
    output logic                  busy,
    output logic                  cmd_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        OP_A,
        OP_B,
        FUN
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic                  alu_en_q, alu_en_d;
    logic                  err_q, err_d;
    logic                  gate_q, gate_d;
    logic                  busy_q, busy_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            fun_q, fun_d;

    logic byte_ok, byte_bad;

    assign byte_ok  = RX_D_VLD & ~RX_PAR_ERR & ~RX_STP_ERR;
    assign byte_bad = RX_D_VLD & (RX_PAR_ERR | RX_STP_ERR);

    // Next-state, timeout and registered-output decode
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_en_d  = 1'b0;
        rd_en_d  = 1'b0;
        alu_en_d = 1'b0;
        err_d    = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        fun_d    = fun_q;

        if (RX_D_VLD || state_q == IDLE) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (byte_bad) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end else if (byte_ok) begin
            case (state_q)
                IDLE: begin
                    if (RX_P_DATA == CMD_WR) begin
                        state_d = WR_ADDR;
                    end else if (RX_P_DATA == CMD_RD) begin
                        state_d = RD_ADDR;
                    end else if (RX_P_DATA == CMD_ALU_OP) begin
                        state_d = OP_A;
                    end else if (RX_P_DATA == CMD_ALU_NOP) begin
                        state_d = FUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                WR_ADDR: begin
                    addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    state_d = WR_DATA;
                end
                WR_DATA: begin
                    wr_en_d = 1'b1;
                    wdata_d = RX_P_DATA;
                    state_d = IDLE;
                end
                RD_ADDR: begin
                    addr_d  = RX_P_DATA[ADDR_WIDTH-1:0];
                    rd_en_d = 1'b1;
                    state_d = IDLE;
                end
                OP_A: begin
                    wr_en_d = 1'b1;
                    addr_d  = '0;
                    wdata_d = RX_P_DATA;
                    state_d = OP_B;
                end
                OP_B: begin
                    wr_en_d = 1'b1;
                    addr_d  = ADDR_WIDTH'(1);
                    wdata_d = RX_P_DATA;
                    state_d = FUN;
                end
                FUN: begin
                    alu_en_d = 1'b1;
                    fun_d    = RX_P_DATA[3:0];
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            // Stalled frame: abandon it; a byte in this same cycle takes priority above
            state_d = IDLE;
            err_d   = 1'b1;
            cnt_d   = '0;
        end

        // Gate stays open through the ALU_EN cycle that follows FUN
        gate_d = (state_d == OP_A) || (state_d == OP_B) || (state_d == FUN) || alu_en_d;
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            alu_en_q <= 1'b0;
            err_q    <= 1'b0;
            gate_q   <= 1'b0;
            busy_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            fun_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_en_q  <= wr_en_d;
            rd_en_q  <= rd_en_d;
            alu_en_q <= alu_en_d;
            err_q    <= err_d;
            gate_q   <= gate_d;
            busy_q   <= busy_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            fun_q    <= fun_d;
        end
    end

    assign WrEn        = wr_en_q;
    assign RdEn        = rd_en_q;
    assign ALU_EN      = alu_en_q;
    assign cmd_err     = err_q;
    assign CLK_GATE_EN = gate_q;
    assign busy        = busy_q;
    assign Address     = addr_q;
    assign WrData      = wdata_q;
    assign ALU_FUN     = fun_q;

endmodule

// File: tb/tb_rx_cmd_ctrl.sv
// Scoreboard bench for rx_cmd_ctrl: directed frames push expected strobes,
// a negedge monitor pops and compares whenever a strobe or cmd_err appears.
module tb_rx_cmd_ctrl;

    localparam int unsigned T_CYC = 16;

    localparam int K_WR  = 0;
    localparam int K_RD  = 1;
    localparam int K_ALU = 2;
    localparam int K_ERR = 3;

    typedef struct {
        int         kind;
        logic [3:0] addr;
        logic [7:0] data;
        logic [3:0] fun;
    } exp_t;

    logic       CLK;
    logic       RST;
    logic [7:0] RX_P_DATA;
    logic       RX_D_VLD;
    logic       RX_PAR_ERR;
    logic       RX_STP_ERR;
    logic       WrEn;
    logic       RdEn;
    logic [3:0] Address;
    logic [7:0] WrData;
    logic       ALU_EN;
    logic [3:0] ALU_FUN;
    logic       CLK_GATE_EN;
    logic       busy;
    logic       cmd_err;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    rx_cmd_ctrl #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .TIMEOUT_CYC(T_CYC)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_P_DATA  (RX_P_DATA),
        .RX_D_VLD   (RX_D_VLD),
        .RX_PAR_ERR (RX_PAR_ERR),
        .RX_STP_ERR (RX_STP_ERR),
        .WrEn       (WrEn),
        .RdEn       (RdEn),
        .Address    (Address),
        .WrData     (WrData),
        .ALU_EN     (ALU_EN),
        .ALU_FUN    (ALU_FUN),
        .CLK_GATE_EN(CLK_GATE_EN),
        .busy       (busy),
        .cmd_err    (cmd_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void push(input int k, input logic [3:0] a, input logic [7:0] d,
                                 input logic [3:0] f);
        exp_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        e.fun  = f;
        exp_q.push_back(e);
    endfunction

    // Drive one byte for one cycle, then hold idle for 'idle' cycles; starts and ends at posedge+1
    task automatic send(input logic [7:0] b, input bit pe, input bit se, input int idle);
        RX_P_DATA  = b;
        RX_PAR_ERR = pe;
        RX_STP_ERR = se;
        RX_D_VLD   = 1'b1;
        @(posedge CLK);
        #1;
        RX_D_VLD   = 1'b0;
        RX_PAR_ERR = 1'b0;
        RX_STP_ERR = 1'b0;
        repeat (idle) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Monitor: every strobe or error pulse must match the head of the scoreboard
    always @(negedge CLK) begin
        if (!RST && (WrEn || RdEn || ALU_EN || cmd_err)) begin
            int   k;
            int   n;
            exp_t e;
            n = int'(WrEn) + int'(RdEn) + int'(ALU_EN) + int'(cmd_err);
            chk("one_hot_strobe", 32'(n), 32'd1);
            k = WrEn ? K_WR : (RdEn ? K_RD : (ALU_EN ? K_ALU : K_ERR));
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event actual=kind%0d required=none", k);
            end else begin
                e = exp_q.pop_front();
                chk("event_kind", 32'(k), 32'(e.kind));
                if (e.kind == K_WR && k == K_WR) begin
                    chk("wr_addr", 32'(Address), 32'(e.addr));
                    chk("wr_data", 32'(WrData), 32'(e.data));
                end else if (e.kind == K_RD && k == K_RD) begin
                    chk("rd_addr", 32'(Address), 32'(e.addr));
                end else if (e.kind == K_ALU && k == K_ALU) begin
                    chk("alu_fun", 32'(ALU_FUN), 32'(e.fun));
                    chk("alu_gate", 32'(CLK_GATE_EN), 32'd1);
                end
            end
        end
    end

    initial begin
        int  cyc;
        bit  seen;
        RST        = 1'b1;
        RX_P_DATA  = '0;
        RX_D_VLD   = 1'b0;
        RX_PAR_ERR = 1'b0;
        RX_STP_ERR = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_outputs", 32'({WrEn, RdEn, ALU_EN, cmd_err, busy, CLK_GATE_EN, Address,
                                  WrData, ALU_FUN}), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        // Register write
        push(K_WR, 4'h5, 8'h3C, 4'h0);
        send(8'hAA, 0, 0, 2);
        chk("busy_mid_wr", 32'(busy), 32'd1);
        send(8'h05, 0, 0, 2);
        send(8'h3C, 0, 0, 2);
        chk("busy_after_wr", 32'(busy), 32'd0);

        // Register read
        push(K_RD, 4'hA, 8'h00, 4'h0);
        send(8'hBB, 0, 0, 2);
        send(8'h0A, 0, 0, 2);
        chk("wrdata_held_after_rd", 32'(WrData), 32'h3C);

        // ALU with operands
        push(K_WR, 4'h0, 8'h12, 4'h0);
        push(K_WR, 4'h1, 8'h34, 4'h0);
        push(K_ALU, 4'h0, 8'h00, 4'h2);
        chk("gate_idle", 32'(CLK_GATE_EN), 32'd0);
        send(8'hCC, 0, 0, 1);
        chk("gate_op_a", 32'(CLK_GATE_EN), 32'd1);
        send(8'h12, 0, 0, 2);
        chk("gate_op_b", 32'(CLK_GATE_EN), 32'd1);
        send(8'h34, 0, 0, 2);
        send(8'h02, 0, 0, 2);
        chk("gate_after_alu", 32'(CLK_GATE_EN), 32'd0);
        chk("addr_held_after_alu", 32'(Address), 32'h1);

        // ALU without operands, then a bad opcode
        push(K_ALU, 4'h0, 8'h00, 4'h7);
        send(8'hDD, 0, 0, 2);
        send(8'h07, 0, 0, 2);
        push(K_ERR, 4'h0, 8'h00, 4'h0);
        send(8'h55, 0, 0, 2);
        chk("busy_after_bad_op", 32'(busy), 32'd0);
        chk("fun_held", 32'(ALU_FUN), 32'h7);

        // Parity error mid-frame, then a clean frame
        push(K_ERR, 4'h0, 8'h00, 4'h0);
        send(8'hAA, 0, 0, 2);
        send(8'h05, 0, 0, 2);
        send(8'h3C, 1, 0, 2);
        chk("busy_after_par_err", 32'(busy), 32'd0);
        push(K_WR, 4'h1, 8'hFF, 4'h0);
        send(8'hAA, 0, 0, 2);
        send(8'h01, 0, 0, 2);
        send(8'hFF, 0, 0, 2);

        // Stop error in RD_ADDR
        push(K_ERR, 4'h0, 8'h00, 4'h0);
        send(8'hBB, 0, 0, 2);
        send(8'h03, 0, 1, 2);
        chk("busy_after_stp_err", 32'(busy), 32'd0);

        // Back-to-back: next opcode arrives in the WrEn cycle
        push(K_WR, 4'h2, 8'h11, 4'h0);
        push(K_RD, 4'h4, 8'h00, 4'h0);
        send(8'hAA, 0, 0, 1);
        send(8'h02, 0, 0, 1);
        send(8'h11, 0, 0, 0);
        send(8'hBB, 0, 0, 1);
        send(8'h04, 0, 0, 3);

        // Inter-byte timeout
        push(K_ERR, 4'h0, 8'h00, 4'h0);
        send(8'hAA, 0, 0, 0);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < int'(T_CYC) + 10) begin
            @(negedge CLK);
            cyc++;
            if (cmd_err) seen = 1'b1;
        end
        chk("timeout_seen", 32'(seen), 32'd1);
        chk("timeout_in_window",
            32'((cyc >= int'(T_CYC) - 1) && (cyc <= int'(T_CYC) + 2)), 32'd1);
        @(posedge CLK);
        #1;
        chk("busy_after_timeout", 32'(busy), 32'd0);

        // Reset mid-frame clears every output at once
        push(K_WR, 4'h0, 8'h12, 4'h0);
        send(8'hCC, 0, 0, 2);
        send(8'h12, 0, 0, 2);
        chk("gate_before_rst", 32'(CLK_GATE_EN), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("midframe_rst_outputs", 32'({WrEn, RdEn, ALU_EN, cmd_err, busy, CLK_GATE_EN,
                                         Address, WrData, ALU_FUN}), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        push(K_ALU, 4'h0, 8'h00, 4'h9);
        send(8'hDD, 0, 0, 2);
        send(8'h09, 0, 0, 4);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
